// File: rtl/mouse_click_filter.sv
// rtl/mouse_click_filter.sv - debounces the MouseCtl left button and reports press-coordinate clicks over valid/ready
module mouse_click_filter #(
    parameter int HOLD_CYCLES = 65000,
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        left_level,
    output logic        click_valid,
    input  logic        click_ready,
    output logic [11:0] click_x,
    output logic [11:0] click_y,
    output logic [7:0]  drop_cnt
);

    localparam logic [16:0] HOLD_LAST  = 17'(HOLD_CYCLES - 1);
    localparam logic [12:0] SCREEN_W_L = 13'(SCREEN_W);
    localparam logic [12:0] SCREEN_H_L = 13'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, PRESS_QUAL, HELD, REL_QUAL} state_t;

    state_t      state;
    state_t      state_next;
    logic        sync_meta;
    logic        ls;
    logic [16:0] hold_cnt;
    logic [11:0] px;
    logic [11:0] py;

    logic        hold_done;
    logic        latch_press;
    logic        press_qualified;
    logic        release_qualified;
    logic        press_in_range;
    logic        load_event;
    logic        drop_event;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       if (ls) state_next = PRESS_QUAL;
                PRESS_QUAL: if (!ls) state_next = IDLE;
                            else if (hold_done) state_next = HELD;
                HELD:       if (!ls) state_next = REL_QUAL;
                REL_QUAL:   if (ls) state_next = HELD;
                            else if (hold_done) state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        hold_done         = (hold_cnt == HOLD_LAST);
        latch_press       = enable && (state == IDLE) && ls;
        press_qualified   = enable && (state == PRESS_QUAL) && ls && hold_done;
        release_qualified = enable && (state == REL_QUAL) && !ls && hold_done;
        press_in_range    = ({1'b0, px} < SCREEN_W_L) && ({1'b0, py} < SCREEN_H_L);
        // A finished click either loads the output slot or is counted as lost when the slot stays full.
        load_event        = release_qualified && press_in_range && (!click_valid || click_ready);
        drop_event        = release_qualified && press_in_range && click_valid && !click_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta   <= 1'b0;
            ls          <= 1'b0;
            hold_cnt    <= '0;
            px          <= '0;
            py          <= '0;
            left_level  <= 1'b0;
            click_valid <= 1'b0;
            click_x     <= '0;
            click_y     <= '0;
            drop_cnt    <= '0;
        end else begin
            sync_meta <= mouse_left;
            ls        <= sync_meta;

            if (!enable || state_next != state) begin
                hold_cnt <= '0;
            end else if (state == PRESS_QUAL || state == REL_QUAL) begin
                hold_cnt <= hold_cnt + 17'd1;
            end

            if (latch_press) begin
                px <= mouse_xpos;
                py <= mouse_ypos;
            end

            if (!enable || release_qualified) begin
                left_level <= 1'b0;
            end else if (press_qualified) begin
                left_level <= 1'b1;
            end

            if (!enable) begin
                click_valid <= 1'b0;
            end else if (load_event) begin
                click_valid <= 1'b1;
                click_x     <= px;
                click_y     <= py;
            end else if (click_valid && click_ready) begin
                click_valid <= 1'b0;
            end

            if (drop_event && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mouse_click_filter.sv
// tb/tb_mouse_click_filter.sv - directed and random checks of mouse_click_filter against a run-length click model
module tb_mouse_click_filter;

    localparam int HOLD = 4;
    localparam int SW   = 1024;
    localparam int SH   = 768;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        left_level;
    logic        click_valid;
    logic        click_ready;
    logic [11:0] click_x;
    logic [11:0] click_y;
    logic [7:0]  drop_cnt;

    int total  = 0;
    int passed = 0;

    // Model: the button level flips after HOLD+1 consecutive synchronised samples of the opposite value.
    logic m_d1, m_d2, m_level, m_valid;
    int   m_run, m_px, m_py, m_x, m_y, m_drop;

    int vcount;
    int cap_x, cap_y;
    logic lvl_high_seen;

    mouse_click_filter #(.HOLD_CYCLES(HOLD), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mouse_left(mouse_left), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .left_level(left_level), .click_valid(click_valid), .click_ready(click_ready),
        .click_x(click_x), .click_y(click_y), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_level = 0; m_valid = 0;
        m_run = 0; m_px = 0; m_py = 0; m_x = 0; m_y = 0; m_drop = 0;
    endtask

    task automatic model_step();
        logic seen, ev, inr, ld;
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = mouse_left;
        if (!enable) begin
            m_level = 0; m_run = 0; m_valid = 0;
            return;
        end
        ev = 0;
        if (seen != m_level) begin
            m_run++;
            if (m_run == 1 && !m_level) begin
                m_px = int'(mouse_xpos);
                m_py = int'(mouse_ypos);
            end
            if (m_run == HOLD + 1) begin
                m_level = seen;
                m_run   = 0;
                ev      = !seen;
            end
        end else begin
            m_run = 0;
        end
        inr = (m_px < SW) && (m_py < SH);
        ld  = ev && inr && (!m_valid || click_ready);
        if (ev && inr && m_valid && !click_ready && m_drop < 255) m_drop++;
        if (ld) begin
            m_valid = 1; m_x = m_px; m_y = m_py;
        end else if (m_valid && click_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("left_level",  32'(left_level),  32'(m_level));
        chk("click_valid", 32'(click_valid), 32'(m_valid));
        chk("click_x",     32'(click_x),     32'(m_x));
        chk("click_y",     32'(click_y),     32'(m_y));
        chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare_all();
        if (click_valid === 1'b1) begin
            vcount++;
            cap_x = int'(click_x);
            cap_y = int'(click_y);
        end
        if (left_level === 1'b1) lvl_high_seen = 1'b1;
    endtask

    task automatic hold(input logic raw, input int n);
        mouse_left = raw;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        vcount = 0; cap_x = -1; cap_y = -1; lvl_high_seen = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; mouse_left = 1'b0;
        mouse_xpos = '0; mouse_ypos = '0; click_ready = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_left_level",  32'(left_level),  0);
        chk("reset_click_valid", 32'(click_valid), 0);
        chk("reset_click_x",     32'(click_x),     0);
        chk("reset_drop_cnt",    32'(drop_cnt),    0);
        rst = 1'b1;
        hold(1'b0, 3);

        // Single clean click, consumer always ready.
        mouse_xpos = 12'd100; mouse_ypos = 12'd200; click_ready = 1'b1;
        clear_obs();
        hold(1'b1, 10);
        hold(1'b0, 10);
        chk("s1_level_rose",   32'(lvl_high_seen), 1);
        chk("s1_level_fell",   32'(left_level),    0);
        chk("s1_valid_cycles", 32'(vcount),        1);
        chk("s1_x",            32'(cap_x),         100);
        chk("s1_y",            32'(cap_y),         200);
        chk("s1_drop",         32'(drop_cnt),      0);

        // Short glitch never qualifies.
        clear_obs();
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk("s2_no_level", 32'(lvl_high_seen), 0);
        chk("s2_no_valid", 32'(vcount),        0);

        // Release bounce collapses to one event.
        clear_obs();
        mouse_xpos = 12'd55; mouse_ypos = 12'd66;
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 10);
        chk("s3_valid_cycles", 32'(vcount), 1);
        chk("s3_x",            32'(cap_x),  55);

        // Three clicks with no consumer: first held, two dropped.
        click_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mouse_xpos = 12'(10 * (i + 1)); mouse_ypos = 12'(20 * (i + 1));
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        chk("s4_valid_held", 32'(click_valid), 1);
        chk("s4_x_first",    32'(click_x),     10);
        chk("s4_y_first",    32'(click_y),     20);
        chk("s4_drop",       32'(drop_cnt),    2);
        click_ready = 1'b1;
        tick();
        click_ready = 1'b0;
        chk("s4_valid_cleared", 32'(click_valid), 0);

        // Off-screen press is discarded without counting.
        click_ready = 1'b1;
        clear_obs();
        mouse_xpos = 12'd1100; mouse_ypos = 12'd50;
        hold(1'b1, 10);
        hold(1'b0, 10);
        chk("s5_no_valid", 32'(vcount),   0);
        chk("s5_drop",     32'(drop_cnt), 2);

        // enable=0 with an event pending.
        click_ready = 1'b0;
        mouse_xpos = 12'd300; mouse_ypos = 12'd301;
        hold(1'b1, 10);
        hold(1'b0, 10);
        chk("s6_pending", 32'(click_valid), 1);
        enable = 1'b0;
        tick();
        chk("s6_en_valid", 32'(click_valid), 0);
        chk("s6_en_drop",  32'(drop_cnt),    2);
        enable = 1'b1;
        hold(1'b0, 3);

        // Asynchronous reset while a release is qualifying.
        clear_obs();
        hold(1'b1, 10);
        hold(1'b0, 3);
        chk("s6_in_release", 32'(left_level), 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("s6_rst_level", 32'(left_level),  0);
        chk("s6_rst_valid", 32'(click_valid), 0);
        chk("s6_rst_x",     32'(click_x),     0);
        chk("s6_rst_drop",  32'(drop_cnt),    0);
        clear_obs();
        tick();
        tick();
        rst = 1'b1;
        hold(1'b0, 12);
        chk("s6_no_event", 32'(vcount), 0);

        // Random segments against the model.
        for (int s = 0; s < 120; s++) begin
            int len;
            len        = int'($urandom_range(1, 9));
            mouse_left = 1'($urandom_range(0, 1));
            mouse_xpos = 12'($urandom_range(0, 1199));
            mouse_ypos = 12'($urandom_range(0, 899));
            enable     = ($urandom_range(0, 14) != 0);
            for (int c = 0; c < len; c++) begin
                click_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
